id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register and operand-forwarding stage that feeds the 16-bit ALU. It captures one decoded instruction per cycle and resolves register operands against the EX/MEM and MEM/WB result buses. It detects load-use hazards, stalling decode and inserting a bubble, and drives the ALU's operand and control inputs (InA, InB, Cin, Oper, invA, invB, sign) from registered state.

## Interface
- `WIDTH`, default 16: datapath width.
- `REG_BITS`, default 3: register specifier width (8 GPRs, all forwardable, no hard-wired zero).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode presents an instruction.
- `id_rs_data`, `id_rt_data` in WIDTH: register-file read values.
- `id_imm` in WIDTH: extended immediate.
- `id_use_imm` in 1: InB comes from the immediate, not from rt.
- `id_rs`, `id_rt` in REG_BITS: source specifiers.
- `id_rs_used`, `id_rt_used` in 1: source is actually read.
- `id_oper` in 4; `id_cin`, `id_inva`, `id_invb`, `id_sign` in 1: ALU controls.
- `id_rd` in REG_BITS; `id_regwrite`, `id_memread` in 1: destination and load flag.
- `exm_valid`, `exm_regwrite` in 1; `exm_rd` in REG_BITS; `exm_result` in WIDTH: EX/MEM producer.
- `mwb_valid`, `mwb_regwrite` in 1; `mwb_rd` in REG_BITS; `mwb_result` in WIDTH: MEM/WB producer.
- `ex_stall` in 1: downstream cannot accept; hold the current contents.
- `flush` in 1: kill the instruction being captured and the one held.
- `stall_id` out 1: decode must hold its instruction.
- `ex_valid` out 1: outputs carry a live instruction.
- `InA`, `InB` out WIDTH: forwarded ALU operands.
- `ex_store_data` out WIDTH: forwarded rt value, independent of `id_use_imm`.
- `Cin`, `invA`, `invB`, `sign` out 1; `Oper` out 4: registered ALU controls.
- `ex_rd` out REG_BITS; `ex_regwrite`, `ex_memread` out 1: gated by `ex_valid`.

## Operation
- State: valid bit, rs/rt data registers, immediate, specifiers, use-flags, and controls.
- Forward select per source, evaluated every cycle on registered state:
  - Match EX/MEM when `exm_valid & exm_regwrite & exm_rd==src & src_used`.
  - Otherwise match MEM/WB under the same rule.
  - Otherwise use the stored value.
  - EX/MEM has priority over MEM/WB.
- `InA` = forwarded rs.
- `InB` = `use_imm` ? immediate : forwarded rt.
- `ex_store_data` = forwarded rt.
- Load-use hazard (combinational) when all of the following hold:
  - `ex_valid & ex_memread` on the held instruction.
  - `id_valid`.
  - `id_rs_used & id_rs==ex_rd`, or `id_rt_used & id_rt==ex_rd`.
- `stall_id` = (`ex_stall` | hazard) & ~`flush`.
- Next-state priority per rising edge:
  1. `flush`: `ex_valid`←0; data and control registers don't-care.
  2. `ex_stall`: hold all control and specifiers. Each stored rs/rt data register is overwritten with its forwarded value (operand refresh), so a producer retiring during the stall is not lost.
  3. Hazard: bubble, `ex_valid`←0. Decode holds its instruction.
  4. Otherwise: capture all `id_*` fields; `ex_valid`←`id_valid`.
- `ex_regwrite`, `ex_memread` = stored flag & `ex_valid`. Controls pass through when invalid; consumers qualify with `ex_valid`.

## Timing
- Reset (async assert, `rst`=0): `ex_valid`=0, all data/specifier/control registers 0. Outputs are therefore `InA`=`InB`=`ex_store_data`=0, `Oper`=0, `Cin`=`invA`=`invB`=`sign`=0, `ex_rd`=0, `ex_regwrite`=`ex_memread`=0, `stall_id`=0. Deassertion is taken synchronously by the next edge.
- Latency: one cycle, `id_*` at edge N drives the outputs after edge N.
- Forward muxing is combinational from `exm_*`/`mwb_*` in the same cycle the ALU consumes the operands.
- Load-use costs exactly one bubble. On the following cycle the load sits in EX/MEM; it is not forwardable as a result until MEM/WB, where the rule above covers it.
- `flush` with `ex_stall` in the same cycle: flush wins.
- `flush` with a hazard: flush wins and `stall_id`=0.
- Reset mid-stall discards the held instruction.
- Back-to-back stalls of any length hold the outputs stable, except operand refresh values.

## Test plan
- Reset mid-operation with `ex_valid`=1 → all outputs 0 immediately, no clock required.
- Capture: `id_rs_data`=0x1234, `id_imm`=0x0005, `use_imm`=1, `Oper`=4'b0001 → next cycle `InA`=0x1234, `InB`=0x0005, `Oper`=0001, `ex_valid`=1.
- Dual forward: EX/MEM writes r2=0xAAAA and MEM/WB writes r2=0x5555, held instruction has rs=r2 → `InA`=0xAAAA. With EX/MEM invalid → `InA`=0x5555.
- Load-use: load to r3 held in EX, decode reads rt=r3 → `stall_id`=1 for one cycle, then `ex_valid`=0 for one cycle, then the dependent captures.
- Stall refresh: `ex_stall`=1 for 3 cycles while MEM/WB writes r4=0xBEEF in cycle 2, held rs=r4 → `InA`=0xBEEF from cycle 2 and after `ex_stall` drops.
- Flush during `ex_stall` and hazard → next cycle `ex_valid`=0, `ex_regwrite`=0, `stall_id`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding
// from the EX/MEM and MEM/WB result buses, plus load-use hazard detection.
// ALU operands and controls are driven from the registered instruction.
module id_ex_stage #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [WIDTH-1:0]    id_rs_data,
  input  logic [WIDTH-1:0]    id_rt_data,
  input  logic [WIDTH-1:0]    id_imm,
  input  logic                id_use_imm,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [3:0]          id_oper,
  input  logic                id_cin,
  input  logic                id_inva,
  input  logic                id_invb,
  input  logic                id_sign,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                exm_valid,
  input  logic                exm_regwrite,
  input  logic [REG_BITS-1:0] exm_rd,
  input  logic [WIDTH-1:0]    exm_result,
  input  logic                mwb_valid,
  input  logic                mwb_regwrite,
  input  logic [REG_BITS-1:0] mwb_rd,
  input  logic [WIDTH-1:0]    mwb_result,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                stall_id,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    InA,
  output logic [WIDTH-1:0]    InB,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic                Cin,
  output logic                invA,
  output logic                invB,
  output logic                sign,
  output logic [3:0]          Oper,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_regwrite,
  output logic                ex_memread
);

  // held instruction state
  logic                valid_q;
  logic [WIDTH-1:0]    rs_data_q;
  logic [WIDTH-1:0]    rt_data_q;
  logic [WIDTH-1:0]    imm_q;
  logic                use_imm_q;
  logic [REG_BITS-1:0] rs_q;
  logic [REG_BITS-1:0] rt_q;
  logic                rs_used_q;
  logic                rt_used_q;
  logic [3:0]          oper_q;
  logic                cin_q;
  logic                inva_q;
  logic                invb_q;
  logic                sign_q;
  logic [REG_BITS-1:0] rd_q;
  logic                regwrite_q;
  logic                memread_q;

  logic [WIDTH-1:0]    fwd_rs;
  logic [WIDTH-1:0]    fwd_rt;
  logic                hazard;

  // forward each source from the youngest matching producer, EX/MEM first
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (exm_valid && exm_regwrite && (exm_rd == rs_q) && rs_used_q) begin
      fwd_rs = exm_result;
    end else if (mwb_valid && mwb_regwrite && (mwb_rd == rs_q) && rs_used_q) begin
      fwd_rs = mwb_result;
    end
    if (exm_valid && exm_regwrite && (exm_rd == rt_q) && rt_used_q) begin
      fwd_rt = exm_result;
    end else if (mwb_valid && mwb_regwrite && (mwb_rd == rt_q) && rt_used_q) begin
      fwd_rt = mwb_result;
    end
  end

  // a held load whose destination is read by decode cannot be forwarded in time
  always_comb begin
    hazard = valid_q && memread_q && id_valid &&
             ((id_rs_used && (id_rs == rd_q)) || (id_rt_used && (id_rt == rd_q)));
    stall_id = (ex_stall || hazard) && !flush;
  end

  // pipeline register: flush, then stall with operand refresh, then bubble, then capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_used_q  <= 1'b0;
      rt_used_q  <= 1'b0;
      oper_q     <= '0;
      cin_q      <= 1'b0;
      inva_q     <= 1'b0;
      invb_q     <= 1'b0;
      sign_q     <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ex_stall) begin
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else if (hazard) begin
      valid_q <= 1'b0;
    end else begin
      valid_q    <= id_valid;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      use_imm_q  <= id_use_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rs_used_q  <= id_rs_used;
      rt_used_q  <= id_rt_used;
      oper_q     <= id_oper;
      cin_q      <= id_cin;
      inva_q     <= id_inva;
      invb_q     <= id_invb;
      sign_q     <= id_sign;
      rd_q       <= id_rd;
      regwrite_q <= id_regwrite;
      memread_q  <= id_memread;
    end
  end

  // ALU-facing outputs; only the side-effecting flags are qualified by valid
  always_comb begin
    ex_valid      = valid_q;
    InA           = fwd_rs;
    InB           = use_imm_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    Oper          = oper_q;
    Cin           = cin_q;
    invA          = inva_q;
    invB          = invb_q;
    sign          = sign_q;
    ex_rd         = rd_q;
    ex_regwrite   = regwrite_q && valid_q;
    ex_memread    = memread_q && valid_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven capture/forwarding vectors plus directed
// sequences for load-use, stall refresh, flush priority and async reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_rs, id_rt;
  logic        id_rs_used, id_rt_used;
  logic [3:0]  id_oper;
  logic        id_cin, id_inva, id_invb, id_sign;
  logic [2:0]  id_rd;
  logic        id_regwrite, id_memread;
  logic        exm_valid, exm_regwrite;
  logic [2:0]  exm_rd;
  logic [15:0] exm_result;
  logic        mwb_valid, mwb_regwrite;
  logic [2:0]  mwb_rd;
  logic [15:0] mwb_result;
  logic        ex_stall, flush;
  logic        stall_id, ex_valid;
  logic [15:0] InA, InB, ex_store_data;
  logic        Cin, invA, invB, sign;
  logic [3:0]  Oper;
  logic [2:0]  ex_rd;
  logic        ex_regwrite, ex_memread;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic [3:0]  oper;
    logic [3:0]  ctl;
    logic [2:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        exm_v;
    logic        exm_rw;
    logic [2:0]  exm_rd;
    logic [15:0] exm_res;
    logic        mwb_v;
    logic        mwb_rw;
    logic [2:0]  mwb_rd;
    logic [15:0] mwb_res;
    logic [15:0] exp_ina;
    logic [15:0] exp_inb;
    logic [15:0] exp_store;
  } vec_t;

  vec_t vecs[8];

  id_ex_stage #(.WIDTH(16), .REG_BITS(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_oper(id_oper),
    .id_cin(id_cin), .id_inva(id_inva), .id_invb(id_invb), .id_sign(id_sign),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .exm_valid(exm_valid), .exm_regwrite(exm_regwrite), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_valid(mwb_valid), .mwb_regwrite(mwb_regwrite),
    .mwb_rd(mwb_rd), .mwb_result(mwb_result), .ex_stall(ex_stall), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .InA(InA), .InB(InB),
    .ex_store_data(ex_store_data), .Cin(Cin), .invA(invA), .invB(invB),
    .sign(sign), .Oper(Oper), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    id_valid    = 1'b1;
    id_rs_data  = v.rs_data;
    id_rt_data  = v.rt_data;
    id_imm      = v.imm;
    id_use_imm  = v.use_imm;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_rs_used  = v.rs_used;
    id_rt_used  = v.rt_used;
    id_oper     = v.oper;
    id_cin      = v.ctl[3];
    id_inva     = v.ctl[2];
    id_invb     = v.ctl[1];
    id_sign     = v.ctl[0];
    id_rd       = v.rd;
    id_regwrite = v.regwrite;
    id_memread  = v.memread;
  endtask

  task automatic setForward(input logic ev, input logic erw, input logic [2:0] erd, input logic [15:0] eres,
                            input logic mv, input logic mrw, input logic [2:0] mrd, input logic [15:0] mres);
    exm_valid = ev; exm_regwrite = erw; exm_rd = erd; exm_result = eres;
    mwb_valid = mv; mwb_regwrite = mrw; mwb_rd = mrd; mwb_result = mres;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    id_valid = 1'b0;
    ex_stall = 1'b0;
    flush    = 1'b0;
    setForward(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick();
  endtask

  task automatic loadInstr(input logic [2:0] rd, input logic memread, input logic [15:0] rs_data, input logic [2:0] rs,
                           input logic rs_used, input logic [3:0] oper);
    vec_t v;
    v = '{rs_data, 16'h0, 16'h0, 1'b0, rs, 3'd0, rs_used, 1'b0, oper, 4'b0000, rd, 1'b1, memread,
          1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0};
    applyStimulus(v);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0F0F, 16'h0005, 1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 4'b0001, 4'b1010, 3'd5, 1'b1, 1'b0,
                1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h0005, 16'h0F0F};
    vecs[1] = '{16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b1, 1'b1, 4'b0010, 4'b0101, 3'd1, 1'b1, 1'b0,
                1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b1, 3'd2, 16'h5555, 16'hAAAA, 16'h2222, 16'h2222};
    vecs[2] = '{16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b1, 1'b1, 4'b0011, 4'b0000, 3'd1, 1'b1, 1'b0,
                1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b1, 3'd2, 16'h5555, 16'h5555, 16'h2222, 16'h2222};
    vecs[3] = '{16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b1, 1'b1, 4'b0100, 4'b1111, 3'd1, 1'b1, 1'b0,
                1'b1, 1'b1, 3'd3, 16'h3333, 1'b1, 1'b1, 3'd2, 16'h4444, 16'h4444, 16'h3333, 16'h3333};
    vecs[4] = '{16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd2, 3'd4, 1'b0, 1'b1, 4'b0101, 4'b0011, 3'd7, 1'b0, 1'b0,
                1'b1, 1'b1, 3'd2, 16'hBBBB, 1'b1, 1'b1, 3'd4, 16'hCCCC, 16'h1111, 16'hCCCC, 16'hCCCC};
    vecs[5] = '{16'h0606, 16'h0660, 16'h7FFF, 1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 4'b1000, 4'b1100, 3'd6, 1'b0, 1'b1,
                1'b1, 1'b0, 3'd6, 16'hDDDD, 1'b1, 1'b1, 3'd6, 16'hEEEE, 16'hEEEE, 16'h7FFF, 16'hEEEE};
    vecs[6] = '{16'h00F0, 16'h8000, 16'h0000, 1'b0, 3'd0, 3'd7, 1'b1, 1'b1, 4'b1111, 4'b0001, 3'd0, 1'b1, 1'b0,
                1'b1, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b1, 3'd7, 16'h9999, 16'h0001, 16'h8000, 16'h8000};
    vecs[7] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, 3'd5, 3'd5, 1'b1, 1'b1, 4'b0110, 4'b0110, 3'd3, 1'b1, 1'b0,
                1'b1, 1'b1, 3'd5, 16'h1357, 1'b1, 1'b1, 3'd5, 16'h2468, 16'h1357, 16'h1357, 16'h1357};

    rst = 1'b0;
    vecs[0].use_imm = 1'b1;
    applyStimulus(vecs[0]);
    id_valid = 1'b0;
    ex_stall = 1'b0;
    flush    = 1'b0;
    setForward(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1;
    checkOutput("reset_ex_valid", ex_valid, 0);
    checkOutput("reset_InA", InA, 0);
    checkOutput("reset_InB", InB, 0);
    checkOutput("reset_store", ex_store_data, 0);
    checkOutput("reset_Oper", Oper, 0);
    checkOutput("reset_ctl", {Cin, invA, invB, sign}, 0);
    checkOutput("reset_ex_rd", ex_rd, 0);
    checkOutput("reset_flags", {ex_regwrite, ex_memread}, 0);
    checkOutput("reset_stall_id", stall_id, 0);
    @(negedge clk);
    rst = 1'b1;

    // capture and forwarding table
    for (int i = 0; i < 8; i++) begin
      idleCycle();
      applyStimulus(vecs[i]);
      tick();
      setForward(vecs[i].exm_v, vecs[i].exm_rw, vecs[i].exm_rd, vecs[i].exm_res,
                 vecs[i].mwb_v, vecs[i].mwb_rw, vecs[i].mwb_rd, vecs[i].mwb_res);
      id_valid = 1'b0;
      #1;
      checkOutput($sformatf("v%0d_ex_valid", i), ex_valid, 1);
      checkOutput($sformatf("v%0d_InA", i), InA, vecs[i].exp_ina);
      checkOutput($sformatf("v%0d_InB", i), InB, vecs[i].exp_inb);
      checkOutput($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_store);
      checkOutput($sformatf("v%0d_Oper", i), Oper, vecs[i].oper);
      checkOutput($sformatf("v%0d_ctl", i), {Cin, invA, invB, sign}, vecs[i].ctl);
      checkOutput($sformatf("v%0d_ex_rd", i), ex_rd, vecs[i].rd);
      checkOutput($sformatf("v%0d_regwrite", i), ex_regwrite, vecs[i].regwrite);
      checkOutput($sformatf("v%0d_memread", i), ex_memread, vecs[i].memread);
    end

    // load-use: one stall_id cycle, one bubble, then the dependent captures
    idleCycle();
    loadInstr(3'd3, 1'b1, 16'h0000, 3'd0, 1'b0, 4'b0000);
    tick();
    id_rs = 3'd1; id_rs_used = 1'b1; id_rt = 3'd3; id_rt_used = 1'b1;
    id_rd = 3'd4; id_memread = 1'b0; id_regwrite = 1'b1;
    #1;
    checkOutput("lu_stall_id", stall_id, 1);
    checkOutput("lu_load_memread", ex_memread, 1);
    tick();
    checkOutput("lu_bubble_valid", ex_valid, 0);
    checkOutput("lu_bubble_stall_id", stall_id, 0);
    checkOutput("lu_bubble_regwrite", ex_regwrite, 0);
    tick();
    checkOutput("lu_dep_valid", ex_valid, 1);
    checkOutput("lu_dep_rd", ex_rd, 4);

    // stall refresh: MEM/WB retires r4 mid-stall, value must survive the stall
    idleCycle();
    loadInstr(3'd2, 1'b0, 16'h0404, 3'd4, 1'b1, 4'b0110);
    tick();
    ex_stall = 1'b1;
    id_rs_data = 16'hFFFF; id_oper = 4'b1001;
    #1;
    checkOutput("st_c1_InA", InA, 16'h0404);
    checkOutput("st_c1_stall_id", stall_id, 1);
    tick();
    setForward(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd4, 16'hBEEF);
    #1;
    checkOutput("st_c2_InA", InA, 16'hBEEF);
    tick();
    setForward(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1;
    checkOutput("st_c3_InA", InA, 16'hBEEF);
    checkOutput("st_c3_Oper", Oper, 4'b0110);
    tick();
    ex_stall = 1'b0;
    id_valid = 1'b0;
    #1;
    checkOutput("st_end_InA", InA, 16'hBEEF);
    checkOutput("st_end_valid", ex_valid, 1);
    checkOutput("st_end_Oper", Oper, 4'b0110);
    checkOutput("st_end_rd", ex_rd, 2);

    // flush beats both ex_stall and a load-use hazard
    idleCycle();
    loadInstr(3'd3, 1'b1, 16'h0000, 3'd0, 1'b0, 4'b0000);
    tick();
    id_rt = 3'd3; id_rt_used = 1'b1; id_memread = 1'b0;
    ex_stall = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("fl_stall_id", stall_id, 0);
    tick();
    flush = 1'b0;
    ex_stall = 1'b0;
    id_valid = 1'b0;
    #1;
    checkOutput("fl_valid", ex_valid, 0);
    checkOutput("fl_regwrite", ex_regwrite, 0);
    checkOutput("fl_memread", ex_memread, 0);
    checkOutput("fl_stall_id_after", stall_id, 0);

    // asynchronous reset with a live instruction held
    idleCycle();
    applyStimulus(vecs[0]);
    tick();
    id_valid = 1'b0;
    #1;
    checkOutput("rm_before_valid", ex_valid, 1);
    rst = 1'b0;
    #1;
    checkOutput("rm_valid", ex_valid, 0);
    checkOutput("rm_InA", InA, 0);
    checkOutput("rm_InB", InB, 0);
    checkOutput("rm_Oper", Oper, 0);
    checkOutput("rm_regwrite", ex_regwrite, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
